// File: rtl/req_agent_ctrl.sv
// req_agent_ctrl: four independent agents that queue jobs,
// request a downstream arbiter and own the resource per burst.
module req_agent_ctrl #(
  parameter int BURST_LEN = 4,
  parameter int MAX_PEND  = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  job,
  input  logic        gnt_0,
  input  logic        gnt_1,
  input  logic        gnt_2,
  input  logic        gnt_3,
  output logic        req_0,
  output logic        req_1,
  output logic        req_2,
  output logic        req_3,
  output logic [3:0]  busy,
  output logic [3:0]  done,
  output logic [3:0]  overflow,
  output logic [11:0] pend_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY,
    RELEASE
  } state_t;

  localparam logic [4:0] LOAD = 5'(BURST_LEN - 1);
  localparam logic [3:0] SAT  = 4'(MAX_PEND);

  logic [3:0] gnt;
  state_t     state   [4];
  state_t     state_n [4];
  logic [4:0] cnt     [4];
  logic [4:0] cnt_n   [4];
  logic [2:0] pend    [4];
  logic [2:0] pend_n  [4];
  logic [3:0] sum     [4];
  logic [3:0] done_n;
  logic [3:0] ovf_n;
  logic [3:0] rq;
  logic [3:0] dec;

  assign gnt = {gnt_3, gnt_2, gnt_1, gnt_0};

  // per-agent next state, burst count and saturating job count
  always_comb begin
    rq     = '0;
    dec    = '0;
    done_n = '0;
    ovf_n  = overflow;
    for (int k = 0; k < 4; k++) begin
      state_n[k] = state[k];
      cnt_n[k]   = cnt[k];
      unique case (state[k])
        IDLE: begin
          if (pend[k] != 3'd0) state_n[k] = REQ;
        end
        REQ: begin
          if (gnt[k]) begin
            state_n[k] = BUSY;
            cnt_n[k]   = LOAD;
            dec[k]     = 1'b1;
          end
        end
        BUSY: begin
          if (!gnt[k]) begin
            state_n[k] = IDLE;
            cnt_n[k]   = 5'd0;
            rq[k]      = 1'b1;
          end else if (cnt[k] == 5'd0) begin
            state_n[k] = RELEASE;
            done_n[k]  = 1'b1;
          end else begin
            cnt_n[k] = cnt[k] - 5'd1;
          end
        end
        RELEASE: begin
          if (!gnt[k]) state_n[k] = IDLE;
        end
        default: state_n[k] = IDLE;
      endcase
      sum[k] = {1'b0, pend[k]} + {3'b0, job[k]}
             + {3'b0, rq[k]};
      if (dec[k] && sum[k] != 4'd0) sum[k] = sum[k] - 4'd1;
      if (sum[k] > SAT) begin
        pend_n[k] = SAT[2:0];
        ovf_n[k]  = 1'b1;
      end else begin
        pend_n[k] = sum[k][2:0];
      end
    end
  end

  // state registers, cleared immediately by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= 5'd0;
        pend[k]  <= 3'd0;
      end
      done     <= '0;
      overflow <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        state[k] <= state_n[k];
        cnt[k]   <= cnt_n[k];
        pend[k]  <= pend_n[k];
      end
      done     <= done_n;
      overflow <= ovf_n;
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    for (int k = 0; k < 4; k++)
      busy[k] = (state[k] == BUSY);
  end

  assign req_0 = (state[0] == REQ) || (state[0] == BUSY);
  assign req_1 = (state[1] == REQ) || (state[1] == BUSY);
  assign req_2 = (state[2] == REQ) || (state[2] == BUSY);
  assign req_3 = (state[3] == REQ) || (state[3] == BUSY);

  assign pend_cnt = {pend[3], pend[2], pend[1], pend[0]};

endmodule

// File: tb/tb_req_agent_ctrl.sv
// tb_req_agent_ctrl: directed scenarios plus random traffic
// checked each cycle against a behavioural agent model.
module tb_req_agent_ctrl;

  localparam int BL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  job = '0;
  logic        gnt_0 = 1'b0;
  logic        gnt_1 = 1'b0;
  logic        gnt_2 = 1'b0;
  logic        gnt_3 = 1'b0;
  logic        req_0, req_1, req_2, req_3;
  logic [3:0]  busy, done, overflow;
  logic [11:0] pend_cnt;
  logic [3:0]  reqv;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pend [4];
  int m_left [4];
  bit m_wait [4];
  bit m_rel  [4];
  bit m_done [4];
  bit m_ovf  [4];

  req_agent_ctrl #(.BURST_LEN(BL)) dut (
    .clock(clock), .reset(reset), .job(job),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .gnt_2(gnt_2), .gnt_3(gnt_3),
    .req_0(req_0), .req_1(req_1),
    .req_2(req_2), .req_3(req_3),
    .busy(busy), .done(done),
    .overflow(overflow), .pend_cnt(pend_cnt)
  );

  assign reqv = {req_3, req_2, req_1, req_0};

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_pend[k] = 0; m_left[k] = 0; m_wait[k] = 0;
      m_rel[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
    end
  endfunction

  // one rising edge: owned-cycle countdown, queue arithmetic
  function automatic void model_step(input logic [3:0] j,
                                     input logic [3:0] g);
    for (int k = 0; k < 4; k++) begin
      int p;
      int add;
      int sub;
      add = j[k] ? 1 : 0;
      sub = 0;
      m_done[k] = 0;
      if (m_rel[k]) begin
        if (!g[k]) m_rel[k] = 0;
      end else if (m_left[k] > 0) begin
        if (!g[k]) begin
          m_left[k] = 0;
          add++;
        end else if (m_left[k] == 1) begin
          m_left[k] = 0;
          m_rel[k] = 1;
          m_done[k] = 1;
        end else begin
          m_left[k]--;
        end
      end else if (m_wait[k]) begin
        if (g[k]) begin
          m_wait[k] = 0;
          m_left[k] = BL;
          sub = 1;
        end
      end else if (m_pend[k] > 0) begin
        m_wait[k] = 1;
      end
      p = m_pend[k] + add - sub;
      if (p < 0) p = 0;
      if (p > 7) begin
        p = 7;
        m_ovf[k] = 1;
      end
      m_pend[k] = p;
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("req%0d", k), 32'(reqv[k]),
          32'(m_wait[k] || m_left[k] > 0));
      chk($sformatf("busy%0d", k), 32'(busy[k]),
          32'(m_left[k] > 0));
      chk($sformatf("done%0d", k), 32'(done[k]),
          32'(m_done[k]));
      chk($sformatf("ovf%0d", k), 32'(overflow[k]),
          32'(m_ovf[k]));
      chk($sformatf("pend%0d", k),
          32'(pend_cnt[3*k +: 3]), 32'(m_pend[k]));
    end
  endtask

  task automatic tick(input logic [3:0] j,
                      input logic [3:0] g);
    job = j;
    {gnt_3, gnt_2, gnt_1, gnt_0} = g;
    @(posedge clock);
    model_step(j, g);
    #1;
    check_all();
  endtask

  // reset pulsed between edges; outputs must clear at once
  task automatic mid_reset(input string tag);
    job = '0;
    {gnt_3, gnt_2, gnt_1, gnt_0} = '0;
    reset = 1'b0;
    #1;
    chk({tag, "_req"}, 32'(reqv), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pend"}, 32'(pend_cnt), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_done"}, 32'(done), 0);
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] gr;
    logic [3:0] jr;
    int ndone;
    model_reset();
    #1 reset = 1'b0;
    #2;
    chk("rst_req", 32'(reqv), 0);
    chk("rst_pend", 32'(pend_cnt), 0);
    #4 reset = 1'b1;

    // single burst on agent 2 with timing milestones
    tick(4'b0100, 4'b0000);
    chk("s30_e1_req", 32'(req_2), 0);
    tick(4'b0000, 4'b0000);
    chk("s30_e2_req", 32'(req_2), 1);
    tick(4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick(4'b0000, 4'b0100);
      chk("s30_busy", 32'(busy[2]), 1);
    end
    tick(4'b0000, 4'b0100);
    chk("s30_e8_done", 32'(done[2]), 1);
    chk("s30_e8_req", 32'(req_2), 0);
    tick(4'b0000, 4'b0100);
    chk("s30_e9_done", 32'(done[2]), 0);
    tick(4'b0000, 4'b0000);
    tick(4'b0000, 4'b0000);
    chk("s30_idle_req", 32'(req_2), 0);

    // reset while agent 2 is busy with three jobs queued
    tick(4'b0100, 4'b0000);
    tick(4'b0000, 4'b0000);
    tick(4'b0000, 4'b0100);
    for (int i = 0; i < 3; i++) tick(4'b0100, 4'b0100);
    chk("s29_pre_busy", 32'(busy[2]), 1);
    chk("s29_pre_pend", 32'(pend_cnt[8:6]), 3);
    mid_reset("s29");

    // eight jobs, no grant: saturate and flag overflow
    for (int i = 0; i < 8; i++) tick(4'b0001, 4'b0000);
    chk("s31_pend0", 32'(pend_cnt[2:0]), 7);
    chk("s31_ovf", 32'(overflow), 32'h1);
    chk("s31_req0", 32'(req_0), 1);
    mid_reset("s31");

    // full queue, job and grant on the same edge
    for (int i = 0; i < 7; i++) tick(4'b1000, 4'b0000);
    tick(4'b0000, 4'b0000);
    tick(4'b1000, 4'b1000);
    chk("s32_pend3", 32'(pend_cnt[11:9]), 7);
    chk("s32_ovf3", 32'(overflow[3]), 0);
    chk("s32_busy3", 32'(busy[3]), 1);
    mid_reset("s32");

    // abort in the second owned cycle re-queues the job
    tick(4'b0010, 4'b0000);
    tick(4'b0000, 4'b0000);
    tick(4'b0000, 4'b0010);
    tick(4'b0000, 4'b0010);
    tick(4'b0000, 4'b0000);
    chk("s33_busy1", 32'(busy[1]), 0);
    chk("s33_pend1", 32'(pend_cnt[5:3]), 1);
    chk("s33_done", 32'(done), 0);
    tick(4'b0000, 4'b0000);
    chk("s33_rereq", 32'(req_1), 1);
    mid_reset("s33");

    // two queued jobs, grant held through the first release
    ndone = 0;
    tick(4'b0001, 4'b0000);
    tick(4'b0001, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0000, 4'b0001);
      ndone += int'(done[0]);
    end
    chk("s34_hold_rel", 32'(req_0), 0);
    tick(4'b0000, 4'b0000);
    tick(4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick(4'b0000, 4'b0001);
      ndone += int'(done[0]);
    end
    chk("s34_ndone", 32'(ndone), 2);
    chk("s34_pend0", 32'(pend_cnt[2:0]), 0);
    mid_reset("s34");

    // random traffic, grants mostly held
    gr = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 9) == 0) gr[k] = ~gr[k];
        jr[k] = ($urandom_range(0, 5) == 0);
      end
      tick(jr, gr);
      if (i % 500 == 499) mid_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
